// File: rtl/tpu_host_ctrl_if.sv
// Host-side stream and tpuv1 bus signals of tpu_host_ctrl.
// master = the sequencer, slave = host FIFOs plus the tpuv1 port.
`timescale 1ns/1ps
interface tpu_host_ctrl_if #(
    parameter int ADDRW = 16,
    parameter int DATAW = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [DATAW-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [DATAW-1:0] out_data;
    logic             tpu_r_w;
    logic [ADDRW-1:0] tpu_addr;
    logic [DATAW-1:0] tpu_wdata;
    logic [DATAW-1:0] tpu_rdata;

    modport master (
        input  in_valid, in_data, out_ready, tpu_rdata,
        output in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_wdata
    );

    modport slave (
        output in_valid, in_data, out_ready, tpu_rdata,
        input  in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_wdata
    );
endinterface

// File: rtl/tpu_host_ctrl.sv
// Host-side job sequencer for tpuv1: load A/B rows, trigger, wait, read back C.
// Optional job cycle counter enabled by defining TPU_HOST_PERF_EN.
`timescale 1ns/1ps
module tpu_host_ctrl #(
    parameter int               BITS_AB     = 8,
    parameter int               BITS_C      = 16,
    parameter int               DIM         = 8,
    parameter int               ADDRW       = 16,
    parameter int               DATAW       = 64,
    parameter int               COMPUTE_CYC = 24,
    parameter logic [ADDRW-1:0] A_BASE      = 16'h0100,
    parameter logic [ADDRW-1:0] B_BASE      = 16'h0200,
    parameter logic [ADDRW-1:0] C_BASE      = 16'h0300,
    parameter logic [ADDRW-1:0] GO_ADDR     = 16'h0400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] perf_cycles,
    tpu_host_ctrl_if.master bus
);
    localparam int ROWW   = DIM * BITS_AB;
    localparam int CW     = (DIM * BITS_C) / DATAW;
    localparam int NWORDS = DIM * CW;
    localparam int IDXW   = $clog2(NWORDS + 1);
    localparam int CNTW   = $clog2(COMPUTE_CYC + 1);

    // One A/B row must fill exactly one bus word.
    if (ROWW != DATAW) begin : g_cfg_err
        $error("tpu_host_ctrl: DIM*BITS_AB must equal DATAW");
    end

    typedef enum logic [3:0] {
        IDLE, LOAD_A, LOAD_B, GO, COMPUTE, RD_ADDR, RD_CAP, RD_HOLD, DONE
    } state_t;

    state_t          state;
    logic [IDXW-1:0] idx;
    logic [CNTW-1:0] cnt;

    function automatic logic [ADDRW-1:0] word_addr(input logic [ADDRW-1:0] base,
                                                   input logic [IDXW-1:0]  i);
        return base + (ADDRW'(i) << 3);
    endfunction

    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign bus.in_ready = (state == LOAD_A) || (state == LOAD_B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            cnt           <= '0;
            bus.tpu_r_w   <= 1'b0;
            bus.tpu_addr  <= '0;
            bus.tpu_wdata <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            // Write strobe is a single-cycle pulse unless re-armed below.
            bus.tpu_r_w <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        state <= LOAD_A;
                    end
                end
                LOAD_A, LOAD_B: begin
                    if (bus.in_valid) begin
                        bus.tpu_r_w   <= 1'b1;
                        bus.tpu_addr  <= word_addr((state == LOAD_A) ? A_BASE : B_BASE, idx);
                        bus.tpu_wdata <= bus.in_data;
                        if (idx == IDXW'(DIM - 1)) begin
                            idx   <= '0;
                            state <= (state == LOAD_A) ? LOAD_B : GO;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                GO: begin
                    bus.tpu_r_w   <= 1'b1;
                    bus.tpu_addr  <= GO_ADDR;
                    bus.tpu_wdata <= '0;
                    cnt           <= '0;
                    state         <= COMPUTE;
                end
                COMPUTE: begin
                    // Read address is set up on exit so it is on the bus during RD_ADDR.
                    if (cnt == CNTW'(COMPUTE_CYC - 1)) begin
                        idx          <= '0;
                        bus.tpu_addr <= C_BASE;
                        state        <= RD_ADDR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RD_ADDR: state <= RD_CAP;
                RD_CAP: begin
                    bus.out_data  <= bus.tpu_rdata;
                    bus.out_valid <= 1'b1;
                    state         <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (idx == IDXW'(NWORDS - 1)) begin
                            state <= DONE;
                        end else begin
                            idx          <= idx + 1'b1;
                            bus.tpu_addr <= word_addr(C_BASE, idx + 1'b1);
                            state        <= RD_ADDR;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TPU_HOST_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (state == IDLE && start) begin
            perf_q <= '0;
        end else if (busy && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif
endmodule

// File: tb/tb_tpu_host_ctrl.sv
// Directed/randomized bench for tpu_host_ctrl with a tagged-data tpuv1 model.
`timescale 1ns/1ps
module tb_tpu_host_ctrl;
    localparam int             DIM    = 8;
    localparam int             CW     = 2;
    localparam int             NW     = DIM * CW;
    localparam int             CCYC   = 24;
    localparam logic [15:0]    A_BASE = 16'h0100;
    localparam logic [15:0]    B_BASE = 16'h0200;
    localparam logic [15:0]    C_BASE = 16'h0300;
    localparam logic [15:0]    GO_A   = 16'h0400;
    localparam int             BASE_DUR = 2*DIM + 1 + CCYC + 3*NW + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [31:0] perf_cycles;

    tpu_host_ctrl_if #(.ADDRW(16), .DATAW(64)) bus();

    tpu_host_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .perf_cycles (perf_cycles),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // tpuv1 read model: data returned one cycle after the address, tagged by address.
    logic [47:0] salt = '0;
    always @(posedge clk) bus.tpu_rdata <= {salt, bus.tpu_addr};

    // Bus/stream monitor: logs writes and C words, checks hold and read ordering.
    logic [79:0] wr_q[$];
    logic [63:0] rd_q[$];
    int          hs_count = 0;

    initial begin : monitor
        logic        prev_ov, prev_or;
        logic [63:0] prev_od;
        logic [15:0] prev_addr;
        prev_ov = 0; prev_or = 0; prev_od = '0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 0;
                prev_addr = bus.tpu_addr;
            end else begin
                if (start && !busy) begin
                    wr_q.delete();
                    rd_q.delete();
                    hs_count = 0;
                end
                if (bus.tpu_r_w) wr_q.push_back({bus.tpu_addr, bus.tpu_wdata});
                if (prev_ov && !prev_or) begin
                    check("out_valid_hold", bus.out_valid, 1);
                    check("out_data_stable", bus.out_data, prev_od);
                end
                if (!bus.tpu_r_w && bus.tpu_addr != prev_addr &&
                    bus.tpu_addr >= C_BASE && bus.tpu_addr < C_BASE + 16'(8*NW))
                    check("read_issue_order", hs_count, (bus.tpu_addr - C_BASE) / 8);
                if (bus.out_valid && bus.out_ready) begin
                    rd_q.push_back(bus.out_data);
                    hs_count++;
                end
                prev_ov   = bus.out_valid;
                prev_or   = bus.out_ready;
                prev_od   = bus.out_data;
                prev_addr = bus.tpu_addr;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},     busy, 0);
        check({tag, "_done"},     done, 0);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_out_valid"},bus.out_valid, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
        check({tag, "_r_w"},      bus.tpu_r_w, 0);
        check({tag, "_addr"},     bus.tpu_addr, 0);
        check({tag, "_wdata"},    bus.tpu_wdata, 0);
        check({tag, "_perf"},     perf_cycles, 0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // One full job; expected writes, C words and duration come from the address map rules.
    task automatic run_job(input bit fixed, input bit stall, input int hold_word, input int hold_len);
        logic [63:0] feed[$];
        logic [79:0] exp_w[$];
        logic [63:0] w;
        int load_stalls = 0, hold_left = hold_len, cyc = 0, done_cyc = -1, busy_cnt = 0, exp_dur;
        salt = 48'({$urandom(), $urandom()});
        for (int k = 0; k < DIM; k++) begin
            w = fixed ? {8{8'h01}} : {$urandom(), $urandom()};
            feed.push_back(w);
            exp_w.push_back({A_BASE + 16'(8*k), w});
        end
        for (int k = 0; k < DIM; k++) begin
            w = fixed ? {8{8'h02}} : {$urandom(), $urandom()};
            feed.push_back(w);
            exp_w.push_back({B_BASE + 16'(8*k), w});
        end
        exp_w.push_back({GO_A, 64'h0});
        pulse_start();
        check("busy_after_start", busy, 1);
        check("in_ready_after_start", bus.in_ready, 1);
        while (done_cyc < 0 && cyc < 2000) begin
            cyc++;
            bus.in_valid  = (feed.size() > 0) && (!stall || cyc[0]);
            bus.in_data   = (feed.size() > 0) ? feed[0] : 64'h0;
            if (feed.size() > 0 && !bus.in_valid) load_stalls++;
            bus.out_ready = !(hs_count == hold_word && hold_left > 0);
            @(negedge clk);
            if (busy) busy_cnt++;
            if (bus.in_valid && bus.in_ready) void'(feed.pop_front());
            if (bus.out_valid && !bus.out_ready) hold_left--;
            if (done) done_cyc = cyc;
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        exp_dur = BASE_DUR + load_stalls + hold_len;
        check("done_cycle", done_cyc, exp_dur);
        check("busy_cycles", busy_cnt, exp_dur);
        check("done_is_pulse", done, 0);
        check("idle_after_job", busy, 0);
        check("write_count", wr_q.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++)
            check($sformatf("write_%0d", i), wr_q[i], exp_w[i]);
        check("c_word_count", rd_q.size(), NW);
        for (int k = 0; k < NW && k < rd_q.size(); k++)
            check($sformatf("c_word_%0d", k), rd_q[k], {salt, C_BASE + 16'(8*k)});
        repeat (3) @(posedge clk);
        #1;
`ifdef TPU_HOST_PERF_EN
        check("perf_cycles", perf_cycles, exp_dur);
`else
        check("perf_cycles", perf_cycles, 0);
`endif
        check("out_valid_after_job", bus.out_valid, 0);
    endtask

    // Start during COMPUTE must be ignored; reset in RD_HOLD must clear everything.
    task automatic reset_midjob();
        logic [63:0] feed[$];
        int cyc = 0;
        bit got = 0;
        salt = 48'({$urandom(), $urandom()});
        for (int k = 0; k < 2*DIM; k++) feed.push_back({$urandom(), $urandom()});
        pulse_start();
        while (!got && cyc < 300) begin
            cyc++;
            bus.in_valid  = (feed.size() > 0);
            bus.in_data   = (feed.size() > 0) ? feed[0] : 64'h0;
            bus.out_ready = 1'b0;
            start         = (cyc == 2*DIM + 6);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) void'(feed.pop_front());
            if (bus.out_valid) got = 1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        bus.in_valid = 1'b0;
        check("reached_rd_hold", got, 1);
        check("writes_before_reset", wr_q.size(), 2*DIM + 1);
        check("c_word_pending", bus.out_valid, 1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1 check_idle_outputs("async_reset");
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("in_reset");
        @(negedge clk) rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("idle_after_reset", busy, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_no_write", bus.tpu_r_w, 0);
            check("idle_not_busy", busy, 0);
        end
        #1 check_idle_outputs("idle");

        run_job(1'b1, 1'b0, -1, 0);
        run_job(1'b0, 1'b1, -1, 0);
        run_job(1'b0, 1'b0, 3, 10);
        reset_midjob();
        run_job(1'b0, 1'b0, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tpu_host_ctrl.md
# tpu_host_ctrl

Bus-initiator sequencer that drives the tpuv1 memory-mapped port (r_w, addr, dataIn, dataOut) from the host side. It runs one full matrix job per start pulse:
- streams DIM A-row words and DIM B-row words from an input stream into the accelerator;
- issues the compute trigger and waits a fixed compute time;
- reads back every C word to an output stream.

It sits between the host FIFOs and tpuv1.

## Interface
- BITS_AB, 8, A/B element width
- BITS_C, 16, C element width
- DIM, 8, array dimension; DIM*BITS_AB == DATAW required
- ADDRW, 16, bus address width
- DATAW, 64, bus data width; C row = CW = DIM*BITS_C/DATAW words (2 at defaults)
- COMPUTE_CYC, 24, cycles waited after trigger before first C read
- A_BASE / B_BASE / C_BASE / GO_ADDR, 16'h0100 / 16'h0200 / 16'h0300 / 16'h0400, address map; word k at BASE + 8*k

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job request, sampled in IDLE only
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid & in_ready
- in_data  in  DATAW  A words then B words, row 0 first
- out_valid  out  1  C word available
- out_ready  in  1  consumer accepts
- out_data  out  DATAW  C word
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- tpu_r_w  out  1  1 = write, 0 = read (to tpuv1 r_w)
- tpu_addr  out  ADDRW  to tpuv1 addr
- tpu_wdata  out  DATAW  to tpuv1 dataIn
- tpu_rdata  in  DATAW  from tpuv1 dataOut; valid the cycle after a read address is presented
- perf_cycles  out  32  job cycle count (see Configuration)

## Operation
- States: IDLE, LOAD_A, LOAD_B, GO, COMPUTE, RD_ADDR, RD_CAP, RD_HOLD, DONE.
- **IDLE**
  - start=1 → LOAD_A; index cleared.
  - start in any other state is ignored.
- **LOAD_A / LOAD_B**
  - in_ready=1.
  - Each accepted beat registers tpu_r_w=1, tpu_addr=BASE+8*idx, tpu_wdata=in_data for exactly the next cycle.
  - Idle bus cycle otherwise: tpu_r_w=0, addr/wdata hold last value.
  - After beat DIM-1: LOAD_A → LOAD_B (idx←0); LOAD_B → GO.
  - in_valid low stalls with no bus write.
- **GO**: one write cycle, addr=GO_ADDR, wdata=0 → COMPUTE.
- **COMPUTE**: counts COMPUTE_CYC cycles with tpu_r_w=0 → RD_ADDR, idx←0.
- **RD_ADDR**: tpu_r_w=0, tpu_addr=C_BASE+8*idx → RD_CAP.
- **RD_CAP**: out_data←tpu_rdata, out_valid←1 → RD_HOLD.
- **RD_HOLD**
  - out_data and out_valid stay stable until out_ready.
  - On the handshake out_valid←0.
  - If idx == DIM*CW-1 → DONE, else idx+1 → RD_ADDR.
- **DONE**: done=1 for one cycle → IDLE.
- C word order: row r low word (columns 0..DIM/CW-1) first, word k = r*CW + half.
- Indices are sized to DIM*CW and never wrap mid-job.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, tpu_r_w=0, tpu_addr=0, tpu_wdata=0, perf_cycles=0, state IDLE.
- Reset asserted mid-job: immediate return to IDLE with reset values. No partial write completes after reset asserts.
- Start sampled at edge t: busy=1 and in_ready=1 from cycle t+1.
- Bus write lands one cycle after its input handshake. At most one bus transaction per cycle.
- Full throughput (in_valid=1, out_ready=1): busy duration = 2*DIM + 1 + COMPUTE_CYC + 3*DIM*CW + 1 cycles (90 at defaults).
- out_valid never drops without a handshake. out_data changes only in RD_CAP.
- start coincident with DONE: ignored; a new job needs start while in IDLE.

## Configuration
- TPU_HOST_PERF_EN defined:
  - perf_cycles clears on the start handshake.
  - It increments every busy cycle, saturating at 32'hFFFF_FFFF.
  - It holds its value after done until the next start.
- TPU_HOST_PERF_EN undefined: counter logic is absent and perf_cycles is tied to 0.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, busy=0, no tpu_r_w pulse.
- Defaults, in_valid=1 and out_ready=1, start at cycle 0 with A words 0x0101..., B words 0x0202...:
  - bus writes to 0x0100..0x0138, then 0x0200..0x0238, then 0x0400;
  - 16 reads at 0x0300..0x0378;
  - done at cycle 90 after start; with TPU_HOST_PERF_EN, perf_cycles=90.
- in_valid toggling 1/0 during load → no bus write in stall cycles, addresses stay contiguous, busy extends by the stall count.
- out_ready low 10 cycles on word 3 → out_valid stays 1 with out_data stable, next read address (0x0320) not issued until the handshake.
- start pulsed during COMPUTE, then rst_n low during RD_HOLD → second start ignored; after reset all outputs 0, state IDLE, a new start runs a full job correctly.
- Model tpuv1 returning address-tagged data → out_data[k] equals the tag for C_BASE+8*k, for k=0..15.
